// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window of clk cycles.
// Optional period measurement between consecutive edges: define FREQ_METER_PERIOD_EN.
module freq_meter #(
    parameter int FPGA_CLK    = 50_000_000,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             ovf,
    output logic             busy
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid
`endif
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t           r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [1:0]       r_arm_cnt;
    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_sat;

    logic             w_rise;
    logic             w_at_max;
    logic             w_last;
    logic [CNT_W-1:0] w_edge_nxt;
    logic             w_sat_nxt;

    assign w_rise     = r_s2 & ~r_s3;
    assign w_at_max   = &r_edge_cnt;
    assign w_last     = (r_gate_cnt == GATE_LAST);
    assign w_edge_nxt = (w_rise && !w_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    assign w_sat_nxt  = r_sat | (w_rise & w_at_max);
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_arm_cnt  <= 2'd0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            freq_out   <= '0;
            ovf        <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_arm_cnt  <= 2'd0;
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_sat      <= 1'b0;
                    if (en) r_state <= ARM;
                end
                // ARM flushes stale synchronizer contents so no phantom edge is counted
                ARM: begin
                    if (!en) begin
                        r_state   <= IDLE;
                        r_arm_cnt <= 2'd0;
                    end else if (r_arm_cnt == 2'd2) begin
                        r_state    <= MEASURE;
                        r_arm_cnt  <= 2'd0;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 2'd1;
                    end
                end
                MEASURE: begin
                    if (w_last) begin
                        freq_out   <= w_edge_nxt;
                        ovf        <= w_sat_nxt;
                        valid      <= 1'b1;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                        if (!en) r_state <= IDLE;
                    end else if (!en) begin
                        r_state    <= IDLE;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + GW'(1);
                        r_edge_cnt <= w_edge_nxt;
                        r_sat      <= w_sat_nxt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] r_per_cnt;
    logic             r_per_arm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_cnt    <= '0;
            r_per_arm    <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
        end else if (r_state != MEASURE) begin
            r_per_cnt    <= '0;
            r_per_arm    <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (w_rise) begin
                if (r_per_arm) begin
                    period_out   <= r_per_cnt;
                    period_valid <= 1'b1;
                end
                r_per_arm <= 1'b1;
                r_per_cnt <= CNT_W'(1);
            end else if (r_per_arm && !(&r_per_cnt)) begin
                r_per_cnt <= r_per_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: gate of 100 cycles, 4-bit counter.
// Window tables, single-pulse boundary tables and hand sequences for abort/reset.
module tb_freq_meter;

    localparam int G = 100;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic         sig_in;
    logic [W-1:0] freq_out;
    logic         valid;
    logic         ovf;
    logic         busy;
`ifdef FREQ_METER_PERIOD_EN
    logic [W-1:0] period_out;
    logic         period_valid;
`endif

    freq_meter #(
        .FPGA_CLK(100),
        .GATE_CYCLES(G),
        .CNT_W(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sig_in(sig_in),
        .freq_out(freq_out),
        .valid(valid),
        .ovf(ovf),
        .busy(busy)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .period_out(period_out),
        .period_valid(period_valid)
`endif
    );

    int checks = 0;
    int errors = 0;
    int sig_per = 0;
    int sig_lvl = 1;
    bit busy_drop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus source: square wave of period sig_per, or level sig_lvl when 0
    initial begin
        int pc;
        int last;
        pc = 0;
        last = 0;
        sig_in = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (sig_per == 0) begin
                sig_in = sig_lvl[0];
                pc = 0;
            end else begin
                if (sig_per != last) pc = 0;
                last = sig_per;
                sig_in = (pc < sig_per / 2);
                pc = (pc + 1) % sig_per;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (!busy) busy_drop = 1'b1;
        end while (!valid && n < 400);
        if (!valid) chk("valid_timeout", 0, 1);
    endtask

    typedef struct {
        int per;
        int lvl;
        int exp_freq;
        int exp_ovf;
    } win_t;

    typedef struct {
        int set_tick;
        int exp1;
        int exp2;
    } pulse_t;

    win_t   wt[10];
    pulse_t pt[4];

    initial begin
        int n;
        bit saw;
        wt[0] = '{10, 0, 10, 0};
        wt[1] = '{4, 0, 15, 1};
        wt[2] = '{10, 0, 10, 0};
        wt[3] = '{20, 0, 5, 0};
        wt[4] = '{5, 0, 15, 1};
        wt[5] = '{25, 0, 4, 0};
        wt[6] = '{0, 1, 0, 0};
        wt[7] = '{50, 0, 2, 0};
        wt[8] = '{100, 0, 1, 0};
        wt[9] = '{10, 0, 10, 0};
        pt[0] = '{1, 0, 0};
        pt[1] = '{2, 1, 0};
        pt[2] = '{101, 1, 0};
        pt[3] = '{102, 0, 1};

        rst = 1'b1;
        en = 1'b0;
        repeat (3) tick();
        chk("reset_freq", int'(freq_out), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_ovf", int'(ovf), 0);
        chk("reset_busy", int'(busy), 0);

        // Input already high when enabled: not an edge
        rst = 1'b0;
        en = 1'b1;
        wait_valid(n);
        chk("first_latency", n, G + 4);
        chk("held_high_freq", int'(freq_out), 0);
        wait_valid(n);
        chk("held_high_interval", n, G);
        chk("held_high_freq2", int'(freq_out), 0);

        foreach (wt[i]) begin
            sig_per = wt[i].per;
            sig_lvl = wt[i].lvl;
            wait_valid(n);
            busy_drop = 1'b0;
            wait_valid(n);
            chk($sformatf("win%0d_interval", i), n, G);
            chk($sformatf("win%0d_freq", i), int'(freq_out), wt[i].exp_freq);
            chk($sformatf("win%0d_ovf", i), int'(ovf), wt[i].exp_ovf);
            chk($sformatf("win%0d_busy", i), int'(busy_drop), 0);
        end

        // Abort mid-window, then re-enable
        tick();
        chk("valid_one_cycle", int'(valid), 0);
        repeat (49) tick();
        en = 1'b0;
        tick();
        chk("abort_busy", int'(busy), 0);
        saw = 1'b0;
        repeat (150) begin
            tick();
            if (valid) saw = 1'b1;
        end
        chk("abort_no_valid", int'(saw), 0);
        chk("abort_freq_hold", int'(freq_out), 10);
        chk("abort_ovf_hold", int'(ovf), 0);
        en = 1'b1;
        wait_valid(n);
        chk("rearm_latency", n, G + 4);
        chk("rearm_freq", int'(freq_out), 10);

        // Synchronous reset in the middle of a window
        sig_per = 4;
        wait_valid(n);
        wait_valid(n);
        chk("pre_rst_freq", int'(freq_out), 15);
        chk("pre_rst_ovf", int'(ovf), 1);
        repeat (60) tick();
        rst = 1'b1;
        tick();
        chk("midrst_freq", int'(freq_out), 0);
        chk("midrst_ovf", int'(ovf), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        sig_per = 20;
        tick();
        chk("post_rst_arm", int'(busy), 1);
        wait_valid(n);
        chk("post_rst_latency", n, G + 3);
        chk("post_rst_freq", int'(freq_out), 5);
        chk("post_rst_ovf", int'(ovf), 0);

        // Single edge placed at the ARM/MEASURE and terminal boundaries
        foreach (pt[i]) begin
            en = 1'b0;
            sig_per = 0;
            sig_lvl = 0;
            repeat (6) tick();
            en = 1'b1;
            repeat (pt[i].set_tick) tick();
            sig_lvl = 1;
            wait_valid(n);
            chk($sformatf("pulse%0d_win1", i), int'(freq_out), pt[i].exp1);
            wait_valid(n);
            chk($sformatf("pulse%0d_win2", i), int'(freq_out), pt[i].exp2);
        end

`ifdef FREQ_METER_PERIOD_EN
        begin
            int pv;
            en = 1'b0;
            sig_per = 10;
            repeat (20) tick();
            en = 1'b1;
            pv = 0;
            repeat (G + 4) begin
                tick();
                if (period_valid) begin
                    pv++;
                    chk("period10", int'(period_out), 10);
                end
            end
            chk("period10_count", pv, 9);
            sig_per = 7;
            repeat (30) tick();
            pv = 0;
            repeat (70) begin
                tick();
                if (period_valid) begin
                    pv++;
                    chk("period7", int'(period_out), 7);
                end
            end
            chk("period7_count", pv, 10);
        end
`endif

        en = 1'b0;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
